instr_fetch: RTL

Instruction-fetch stage of the single-issue RV32 core. It sits directly upstream of the decode/register-file stage. It owns the program counter, issues word requests to instruction memory and tolerates variable in-order response latency. It buffers returned instructions in a small FIFO and hands `{pc, instr}` pairs to decode over a valid/ready handshake. Branch/jump redirects from execute flush all in-flight and buffered work.

---
 rtl/riscv_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/instr_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int unsigned      XLEN             = 32;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO of {pc, instr} entries with flush, occupancy
// count and a registered head view.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [CW-1:0] occ_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Next-state for storage, pointers and occupancy; flush dominates.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        do_push_s = push_i && (occ_q != CW'(DEPTH));
        do_pop_s  = pop_i && (occ_q != '0);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            occ_d = occ_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // State registers; storage cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction-fetch stage: PC, request credit, stale-response dropping.
// Optional misaligned-redirect fault/halt under IFETCH_MISALIGN_CHK_EN.
module instr_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_fault
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   occ_s;
    logic [CW:0]     credit_s;
    logic            halt_s;
    logic            req_fire_s;
    logic            rsp_fire_s;
    logic            push_s;
    logic            pop_s;
    logic [XLEN-1:0] rsp_pc_s;
    fetch_entry_t    push_data_s;
    fetch_entry_t    head_s;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic fault_q, fault_d;

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
        end else begin
            fault_d = fault_q;
        end
    end

    // Fault register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign halt_s      = fault_q;
    assign instr_fault = fault_q;
`else
    assign halt_s      = 1'b0;
    assign instr_fault = 1'b0;
`endif

    assign credit_s       = {1'b0, out_cnt_q} + {1'b0, occ_s};
    assign imem_req_valid = !rst && !redirect_valid && !halt_s && (credit_s < DEPTH_W);
    assign imem_addr      = pc_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign rsp_fire_s     = imem_rsp_valid && (out_cnt_q != '0);

    // Once no stale responses remain, outstanding requests are contiguous up to pc.
    assign rsp_pc_s    = pc_q - (XLEN'(out_cnt_q) << 2);
    assign push_data_s = '{pc: rsp_pc_s, instr: imem_rsp_data};

    assign instr_valid = (occ_s != '0) && !redirect_valid;
    assign pop_s       = instr_valid && instr_ready;
    assign instr_o     = head_s.instr;
    assign pc_o        = head_s.pc;

    // PC, outstanding and drop bookkeeping; a redirect turns all in-flight work stale.
    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        push_s     = 1'b0;
        if (redirect_valid) begin
            pc_d       = redirect_pc & 32'hFFFF_FFFC;
            out_cnt_d  = out_cnt_q - CW'(rsp_fire_s);
            drop_cnt_d = out_cnt_q - CW'(rsp_fire_s);
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            out_cnt_d = out_cnt_q + CW'(req_fire_s) - CW'(rsp_fire_s);
            if (rsp_fire_s && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else if (rsp_fire_s) begin
                push_s = 1'b1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (push_s),
        .push_data_i(push_data_s),
        .pop_i      (pop_s),
        .occ_o      (occ_s),
        .head_o     (head_s)
    );

endmodule
